// File: rtl/stim_burst_ctrl.sv
// -----------------------------------------------------------------------------
// stim_burst_ctrl
//
// Stimulation burst sequencer for the stimulus output stage. An accepted start
// latches pulse width, pulse period and pulse count, then a train of
// rectangular pulses is emitted on stim_out. stim_en runs the downstream
// gated-clock stimulus stage and is high for exactly the duration of the burst.
//
// Handshake (start/busy/done):
//   start is sampled only while the FSM is idle. When it is sampled high the
//   configuration is latched and, one cycle later, either busy rises (valid
//   configuration) or done pulses with err=1 (rejected configuration). While
//   busy, and during the single done cycle, start is ignored and nothing is
//   queued. done is a one-cycle strobe. err, aborted and pulses_done are valid
//   with done and hold until the next accepted start.
//
// Ports:
//   clk           in   1      system clock, rising edge
//   rst           in   1      asynchronous reset, active-low
//   start         in   1      burst request (idle only)
//   abort         in   1      terminate a running burst
//   pulse_width   in   CNT_W  high time in clk cycles
//   pulse_period  in   CNT_W  pulse-to-pulse period in clk cycles
//   pulse_count   in   NUM_W  pulses per burst
//   stim_out      out  1      registered pulse train
//   stim_en       out  1      run enable to stimulus stage (high = run)
//   busy          out  1      high while a burst is running
//   done          out  1      one-cycle end-of-burst strobe
//   err           out  1      with done: configuration rejected
//   aborted       out  1      with done: burst terminated by abort
//   pulses_done   out  NUM_W  pulses completed in current/last burst
//   dbg_state     out  2      FSM state (0 idle, 1 high, 2 low, 3 done)
// -----------------------------------------------------------------------------
module stim_burst_ctrl #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] pulse_period,
   input  logic [NUM_W-1:0] pulse_count,
   output logic             stim_out,
   output logic             stim_en,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             aborted,
   output logic [NUM_W-1:0] pulses_done,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_q,       state_d;
   logic [CNT_W-1:0] phase_q,       phase_d;
   logic [CNT_W-1:0] width_q,       width_d;
   logic [CNT_W-1:0] period_q,      period_d;
   logic [NUM_W-1:0] count_q,       count_d;
   logic [NUM_W-1:0] pulses_done_q, pulses_done_d;
   logic             stim_out_q,    stim_out_d;
   logic             stim_en_q,     stim_en_d;
   logic             busy_q,        busy_d;
   logic             done_q,        done_d;
   logic             err_q,         err_d;
   logic             aborted_q,     aborted_d;

   logic             cfg_bad;

   // A burst needs at least one pulse, a non-zero high time and a non-zero
   // low time; anything else is reported through err instead of run.
   assign cfg_bad = (pulse_width == '0) || (pulse_count == '0) ||
                    (pulse_period <= pulse_width);

   // Next-state and next-output logic. phase_q counts down the cycles left in
   // the current HIGH or LOW phase; the phase ends in the cycle it reads zero.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      width_d       = width_q;
      period_d      = period_q;
      count_d       = count_q;
      pulses_done_d = pulses_done_q;
      stim_out_d    = stim_out_q;
      stim_en_d     = stim_en_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = err_q;
      aborted_d     = aborted_q;

      case (state_q)
         ST_IDLE: begin
            // start has priority over abort here: abort only acts on a
            // running burst.
            if (start) begin
               width_d       = pulse_width;
               period_d      = pulse_period;
               count_d       = pulse_count;
               pulses_done_d = '0;
               aborted_d     = 1'b0;
               if (cfg_bad) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d    = ST_HIGH;
                  phase_d    = pulse_width - CNT_W'(1);
                  stim_out_d = 1'b1;
                  stim_en_d  = 1'b1;
                  busy_d     = 1'b1;
                  err_d      = 1'b0;
               end
            end
         end

         ST_HIGH: begin
            if (abort) begin
               // Abort wins over the HIGH->LOW transition, so a pulse cut
               // short is never counted as completed.
               state_d    = ST_DONE;
               stim_out_d = 1'b0;
               stim_en_d  = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               aborted_d  = 1'b1;
            end else if (phase_q == '0) begin
               state_d       = ST_LOW;
               stim_out_d    = 1'b0;
               pulses_done_d = pulses_done_q + NUM_W'(1);
               phase_d       = period_q - width_q - CNT_W'(1);
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end

         ST_LOW: begin
            if (abort) begin
               state_d    = ST_DONE;
               stim_out_d = 1'b0;
               stim_en_d  = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               aborted_d  = 1'b1;
            end else if (phase_q == '0) begin
               if (pulses_done_q == count_q) begin
                  state_d   = ST_DONE;
                  stim_en_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  state_d    = ST_HIGH;
                  stim_out_d = 1'b1;
                  phase_d    = width_q - CNT_W'(1);
               end
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end

         ST_DONE: begin
            // Single-cycle state: start is deliberately not looked at here.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         width_q       <= '0;
         period_q      <= '0;
         count_q       <= '0;
         pulses_done_q <= '0;
         stim_out_q    <= 1'b0;
         stim_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         width_q       <= width_d;
         period_q      <= period_d;
         count_q       <= count_d;
         pulses_done_q <= pulses_done_d;
         stim_out_q    <= stim_out_d;
         stim_en_q     <= stim_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         aborted_q     <= aborted_d;
      end
   end

   assign stim_out    = stim_out_q;
   assign stim_en     = stim_en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign aborted     = aborted_q;
   assign pulses_done = pulses_done_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_stim_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stim_burst_ctrl
//
// Directed bench for stim_burst_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge. "Cycle c" is the c-th clock period after the rising
// edge that samples start; a value set at the falling edge of cycle c is seen
// by the rising edge that ends cycle c.
// -----------------------------------------------------------------------------
module tb_stim_burst_ctrl;

   localparam int CNT_W = 16;
   localparam int NUM_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] pulse_width;
   logic [CNT_W-1:0] pulse_period;
   logic [NUM_W-1:0] pulse_count;
   logic             stim_out;
   logic             stim_en;
   logic             busy;
   logic             done;
   logic             err;
   logic             aborted;
   logic [NUM_W-1:0] pulses_done;
   logic [1:0]       dbg_state;

   int checks;
   int failures;

   stim_burst_ctrl #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .pulse_width  (pulse_width),
      .pulse_period (pulse_period),
      .pulse_count  (pulse_count),
      .stim_out     (stim_out),
      .stim_en      (stim_en),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .aborted      (aborted),
      .pulses_done  (pulses_done),
      .dbg_state    (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output vector: {stim_out, stim_en, busy, done, pulses_done}.
   function automatic logic [NUM_W+3:0] obs_vec();
      return {stim_out, stim_en, busy, done, pulses_done};
   endfunction

   // Reference waveform of a burst (w, p, c) at cycle cyc >= 1, computed from
   // the pulse geometry: pulse k is high in cycles k*p+1 .. k*p+w. abort_cyc
   // is the last cycle in which abort is sampled (0 = no abort).
   function automatic logic [NUM_W+3:0] model(input int w, input int p,
                                              input int c, input int cyc,
                                              input int abort_cyc);
      int   last;
      int   ph;
      int   pd;
      logic s;
      logic b;
      logic d;
      last = (abort_cyc > 0) ? abort_cyc : p * c;
      if (cyc <= last) begin
         ph = (cyc - 1) % p;
         s  = (ph < w);
         pd = (cyc - 1) / p + ((ph >= w) ? 1 : 0);
         b  = 1'b1;
         d  = 1'b0;
      end else begin
         s = 1'b0;
         b = 1'b0;
         d = (cyc == last + 1);
         if (abort_cyc > 0) begin
            ph = (last - 1) % p;
            pd = (last - 1) / p + ((ph >= w) ? 1 : 0);
         end else begin
            pd = c;
         end
      end
      return {s, b, b, d, pd[NUM_W-1:0]};
   endfunction

   // ---------------------------------------------------------------- driver
   task automatic drive_start(input int w, input int p, input int c);
      @(negedge clk);
      start        = 1'b1;
      pulse_width  = CNT_W'(w);
      pulse_period = CNT_W'(p);
      pulse_count  = NUM_W'(c);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      pulse_width  = '0;
      pulse_period = '0;
      pulse_count  = '0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({obs_vec(), err, aborted, dbg_state} !== '0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0", {obs_vec(), err, aborted, dbg_state});
      end
      idle_cycles(3);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({obs_vec(), err, aborted, dbg_state} !== '0) begin
         failures++;
         $display("FAIL reset_release got=%h exp=0", {obs_vec(), err, aborted, dbg_state});
      end
   endtask

   // w=3 p=10 c=4; inputs scrambled right after acceptance.
   task automatic test_basic_burst();
      drive_start(3, 10, 4);
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== model(3, 10, 4, c, 0)) begin
            failures++;
            $display("FAIL basic_burst cyc=%0d got=%h exp=%h", c, obs_vec(), model(3, 10, 4, c, 0));
         end
         if (c == 41) begin
            checks++;
            if ({done, err, aborted, pulses_done, dbg_state} !== {1'b1, 1'b0, 1'b0, 8'd4, 2'd3}) begin
               failures++;
               $display("FAIL basic_done got=%h exp=%h", {done, err, aborted, pulses_done, dbg_state},
                        {1'b1, 1'b0, 1'b0, 8'd4, 2'd3});
            end
         end
         if (c == 1) begin
            start        = 1'b0;
            pulse_width  = 16'd1;
            pulse_period = 16'd1;
            pulse_count  = 8'd0;
         end
      end
   endtask

   // Narrowest legal pulse (w=1 p=2) and maximum pulse count.
   task automatic test_max_count();
      drive_start(1, 2, 255);
      for (int c = 1; c <= 513; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== model(1, 2, 255, c, 0)) begin
            failures++;
            $display("FAIL max_count cyc=%0d got=%h exp=%h", c, obs_vec(), model(1, 2, 255, c, 0));
         end
         if (c == 511) begin
            checks++;
            if ({done, err, pulses_done} !== {1'b1, 1'b0, 8'd255}) begin
               failures++;
               $display("FAIL max_count_done got=%h exp=%h", {done, err, pulses_done}, {1'b1, 1'b0, 8'd255});
            end
         end
         if (c == 1) start = 1'b0;
      end
   endtask

   // Rejected configurations: period==width, width==0, count==0.
   task automatic test_reject();
      int cfg[3][3] = '{'{5, 5, 2}, '{0, 4, 1}, '{2, 4, 0}};
      for (int k = 0; k < 3; k++) begin
         drive_start(cfg[k][0], cfg[k][1], cfg[k][2]);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({stim_out, stim_en, busy, done, err, aborted} !== 6'b000110) begin
            failures++;
            $display("FAIL reject_done cfg=%0d got=%b exp=000110", k,
                     {stim_out, stim_en, busy, done, err, aborted});
         end
         for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({stim_out, stim_en, busy, done, err} !== 5'b00001) begin
               failures++;
               $display("FAIL reject_hold cfg=%0d cyc=%0d got=%b exp=00001", k, c,
                        {stim_out, stim_en, busy, done, err});
            end
         end
      end
   endtask

   // w=4 p=8 c=10, abort in the 3rd HIGH phase (cycles 17..20), sampled at
   // the end of cycle 18. Then: abort in idle, and abort together with start.
   task automatic test_abort();
      drive_start(4, 8, 10);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== model(4, 8, 10, c, 18)) begin
            failures++;
            $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs_vec(), model(4, 8, 10, c, 18));
         end
         if (c == 19 || c == 22) begin
            checks++;
            if ({stim_out, err, aborted, pulses_done} !== {1'b0, 1'b0, 1'b1, 8'd2}) begin
               failures++;
               $display("FAIL abort_status cyc=%0d got=%h exp=%h", c,
                        {stim_out, err, aborted, pulses_done}, {1'b0, 1'b0, 1'b1, 8'd2});
            end
         end
         if (c == 1) start = 1'b0;
         abort = (c == 18);
      end
      abort = 1'b1;
      idle_cycles(2);
      abort = 1'b0;
      checks++;
      if ({busy, done, stim_en, dbg_state} !== 5'b0) begin
         failures++;
         $display("FAIL abort_idle got=%b exp=00000", {busy, done, stim_en, dbg_state});
      end
      drive_start(2, 4, 1);
      abort = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== model(2, 4, 1, c, 0)) begin
            failures++;
            $display("FAIL abort_start_same cyc=%0d got=%h exp=%h", c, obs_vec(), model(2, 4, 1, c, 0));
         end
         if (c == 1) begin
            start = 1'b0;
            abort = 1'b0;
         end
      end
   endtask

   // Repeat of the basic burst with stray starts while busy (cycles 5, 20,
   // 40) and in the done cycle (41); a start in cycle 42 opens a new burst.
   task automatic test_back_to_back();
      logic [NUM_W+3:0] exp;
      drive_start(3, 10, 4);
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         exp = (c <= 42) ? model(3, 10, 4, c, 0) : model(2, 4, 1, c - 42, 0);
         checks++;
         if (obs_vec() !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs_vec(), exp);
         end
         if (c == 42) begin
            checks++;
            if ({err, aborted, dbg_state} !== 4'b0) begin
               failures++;
               $display("FAIL back_to_back_idle got=%b exp=0000", {err, aborted, dbg_state});
            end
         end
         start = (c == 5 || c == 20 || c == 40 || c == 41 || c == 42);
         if (c == 42) begin
            pulse_width  = 16'd2;
            pulse_period = 16'd4;
            pulse_count  = 8'd1;
         end else if (start) begin
            pulse_width  = 16'd1;
            pulse_period = 16'd2;
            pulse_count  = 8'd1;
         end
      end
   endtask

   // Reset asserted between clock edges during a HIGH phase.
   task automatic test_reset_mid_burst();
      drive_start(4, 8, 3);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({stim_out, busy} !== 2'b11) begin
         failures++;
         $display("FAIL rst_mid_pre got=%b exp=11", {stim_out, busy});
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stim_out, stim_en, busy, done, pulses_done, dbg_state} !== '0) begin
         failures++;
         $display("FAIL rst_mid_async got=%h exp=0", {stim_out, stim_en, busy, done, pulses_done, dbg_state});
      end
      idle_cycles(2);
      rst = 1'b1;
      idle_cycles(2);
      checks++;
      if ({obs_vec(), dbg_state} !== '0) begin
         failures++;
         $display("FAIL rst_mid_idle got=%h exp=0", {obs_vec(), dbg_state});
      end
      drive_start(2, 3, 2);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== model(2, 3, 2, c, 0)) begin
            failures++;
            $display("FAIL rst_mid_restart cyc=%0d got=%h exp=%h", c, obs_vec(), model(2, 3, 2, c, 0));
         end
         if (c == 1) start = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_burst();
      idle_cycles(2);
      test_max_count();
      idle_cycles(2);
      test_reject();
      idle_cycles(2);
      test_abort();
      idle_cycles(2);
      test_back_to_back();
      idle_cycles(2);
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
